// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR output post-processing stage.
// Saturation limits, the rounding constant and the FIFO pointer width come from these functions.
package fir_pkg;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Adding half an output LSB before the shift gives round-half-up.
    function automatic longint round_const(input int shift);
        return longint'(1) <<< (shift - 1);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted only
// if a pop happens in the same cycle; a pop while empty is ignored.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/fir_out_proc.sv
// FIR output post-processing: decimate, round half-up, saturate, then buffer in a FIFO.
// The FIR core cannot stall, so samples arriving at a full FIFO are dropped and flagged.
module fir_out_proc
    import fir_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 34,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHIFT          = 15,
    parameter int DECIM_WIDTH    = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      decim_cfg_vld_i,
    input  logic [DECIM_WIDTH-1:0]    decim_cfg_i,
    input  logic                      data_vld_i,
    input  logic [DATA_IN_WIDTH-1:0]  data_i,
    input  logic                      data_rdy_i,
    output logic                      data_vld_o,
    output logic [DATA_OUT_WIDTH-1:0] data_o,
    input  logic                      ovf_clr_i,
    output logic                      ovf_o,
    output logic                      drop_o
);

    localparam int XW = DATA_IN_WIDTH + 1;
    localparam int RW = XW - SHIFT;
    localparam logic signed [RW-1:0] R_MAX = RW'(sat_max(DATA_OUT_WIDTH));
    localparam logic signed [RW-1:0] R_MIN = RW'(sat_min(DATA_OUT_WIDTH));
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = DATA_OUT_WIDTH'(sat_max(DATA_OUT_WIDTH));
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = DATA_OUT_WIDTH'(sat_min(DATA_OUT_WIDTH));
    localparam logic signed [XW-1:0] RND = XW'(round_const(SHIFT));

    logic [DECIM_WIDTH-1:0]    dec_q;
    logic [DECIM_WIDTH-1:0]    cnt;
    logic [DECIM_WIDTH-1:0]    dec_eff;
    logic [DECIM_WIDTH-1:0]    cnt_eff;
    logic                      keep;
    logic signed [XW-1:0]      ext;
    logic                      s1_vld;
    logic signed [RW-1:0]      s1_r;
    logic                      s2_vld;
    logic                      s2_ovf;
    logic [DATA_OUT_WIDTH-1:0] s2_data;
    logic                      fifo_full;
    logic                      fifo_empty;

    // A config load in the same cycle as a sample applies to that sample.
    always_comb begin
        dec_eff = decim_cfg_vld_i ? decim_cfg_i : dec_q;
        cnt_eff = decim_cfg_vld_i ? '0 : cnt;
        keep    = data_vld_i && (cnt_eff == '0);
    end

    assign ext = {data_i[DATA_IN_WIDTH-1], data_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q   <= '0;
            cnt     <= '0;
            s1_vld  <= 1'b0;
            s1_r    <= '0;
            s2_vld  <= 1'b0;
            s2_ovf  <= 1'b0;
            s2_data <= '0;
            ovf_o   <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            if (decim_cfg_vld_i) dec_q <= decim_cfg_i;
            if (data_vld_i)
                cnt <= (cnt_eff == dec_eff) ? '0 : cnt_eff + DECIM_WIDTH'(1);
            else if (decim_cfg_vld_i)
                cnt <= '0;

            s1_vld <= keep;
            s1_r   <= RW'((ext + RND) >>> SHIFT);

            s2_vld <= s1_vld;
            if (s1_r > R_MAX) begin
                s2_data <= OUT_MAX;
                s2_ovf  <= 1'b1;
            end else if (s1_r < R_MIN) begin
                s2_data <= OUT_MIN;
                s2_ovf  <= 1'b1;
            end else begin
                s2_data <= s1_r[DATA_OUT_WIDTH-1:0];
                s2_ovf  <= 1'b0;
            end

            // A new overflow wins over a clear in the same cycle.
            if (s2_vld && s2_ovf) ovf_o <= 1'b1;
            else if (ovf_clr_i)   ovf_o <= 1'b0;

            drop_o <= s2_vld && fifo_full && !data_rdy_i;
        end
    end

    // Output handshake: a sample transfers on any rising edge where data_vld_o and
    // data_rdy_i are both high; data_o holds steady while data_vld_o && !data_rdy_i.
    assign data_vld_o = !fifo_empty;

    fir_out_fifo #(
        .WIDTH (DATA_OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_vld),
        .pop   (data_rdy_i),
        .wdata (s2_data),
        .rdata (data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
